// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole timing slice.
// Sequencer state encoding, mole geometry and the LFSR tap mask.
package whack_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GAP  = 3'd1,
      UP   = 3'd2,
      OVER = 3'd3
   } seq_state_t;

   localparam int NUM_MOLES = 4;
   localparam int MOLE_W    = 2;

   // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick generator: one-cycle tick every TICK_DIV enabled clocks.
// Ports: clk, reset (async, high), clear (restart count),
//        enable (count this cycle), tick (count reached TICK_DIV-1).
module tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = enable && (r_cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= tick ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole sequencer: picks moles, times up/gap windows,
// judges whacks, keeps score and misses, flags game over.
// Ports: clk, reset (async, high), start, whack_valid, whack_idx in;
//        mole_valid, mole_idx, hit_pulse, miss_pulse, score,
//        misses, game_over, seq_state out (all registered).
module mole_sequencer
   import whack_pkg::*;
#(
   parameter int         TICK_DIV   = 5000000,
   parameter int         UP_TICKS   = 10,
   parameter int         GAP_TICKS  = 5,
   parameter int         MAX_MISSES = 3,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              whack_valid,
   input  logic [MOLE_W-1:0] whack_idx,
   output logic              mole_valid,
   output logic [MOLE_W-1:0] mole_idx,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic [7:0]        score,
   output logic [3:0]        misses,
   output logic              game_over,
   output logic [2:0]        seq_state
);

   localparam int MAXT = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
   localparam int CDW  = $clog2(MAXT + 1);

   seq_state_t        r_state;
   logic [7:0]        r_lfsr;
   logic [CDW-1:0]    r_countdown;

   logic              w_tick;
   logic              w_tick_en;
   logic              w_last_tick;
   logic              w_hit;
   logic              w_start;
   logic              w_clear;
   logic [MOLE_W-1:0] w_pick;
   logic [3:0]        w_miss_next;

   assign w_tick_en   = (r_state == GAP) || (r_state == UP);
   assign w_last_tick = w_tick && (r_countdown == CDW'(1));
   assign w_hit       = (r_state == UP) && whack_valid
                        && (whack_idx == mole_idx);
   assign w_start     = start && ((r_state == IDLE) || (r_state == OVER));
   // any entry into GAP or UP restarts the tick phase
   assign w_clear     = w_start || w_hit || (w_tick_en && w_last_tick);
   // never show the same hole twice in a row
   assign w_pick      = (r_lfsr[1:0] == mole_idx) ? r_lfsr[1:0] + 2'd1
                                                  : r_lfsr[1:0];
   assign w_miss_next = misses + 4'd1;
   assign seq_state   = r_state;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .enable(w_tick_en),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_countdown <= '0;
         mole_valid  <= 1'b0;
         mole_idx    <= '0;
         hit_pulse   <= 1'b0;
         miss_pulse  <= 1'b0;
         score       <= '0;
         misses      <= '0;
         game_over   <= 1'b0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         unique case (r_state)
            IDLE, OVER: begin
               if (start) begin
                  r_state     <= GAP;
                  r_countdown <= CDW'(GAP_TICKS);
                  score       <= '0;
                  misses      <= '0;
                  game_over   <= 1'b0;
               end
            end
            GAP: begin
               if (w_last_tick) begin
                  r_state     <= UP;
                  r_countdown <= CDW'(UP_TICKS);
                  mole_valid  <= 1'b1;
                  mole_idx    <= w_pick;
               end else if (w_tick) begin
                  r_countdown <= r_countdown - CDW'(1);
               end
            end
            UP: begin
               // a hit wins over a simultaneous timeout
               if (w_hit) begin
                  hit_pulse   <= 1'b1;
                  mole_valid  <= 1'b0;
                  r_state     <= GAP;
                  r_countdown <= CDW'(GAP_TICKS);
                  if (score != 8'hFF) begin
                     score <= score + 8'd1;
                  end
               end else if (w_last_tick) begin
                  miss_pulse <= 1'b1;
                  mole_valid <= 1'b0;
                  misses     <= w_miss_next;
                  if (w_miss_next == 4'(MAX_MISSES)) begin
                     r_state   <= OVER;
                     game_over <= 1'b1;
                  end else begin
                     r_state     <= GAP;
                     r_countdown <= CDW'(GAP_TICKS);
                  end
               end else if (w_tick) begin
                  r_countdown <= r_countdown - CDW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mole_sequencer.md
Name: mole_sequencer

Overview:
- Upstream game-timing stage for the whack-a-mole game; feeds the game FSM and the drawing stage.
- Chooses which of 4 moles appears, using a pseudo-random source.
- Times each mole's visible window and the gap between moles, and judges whacks as hits or misses.
- Keeps score and miss count, and raises game_over when the miss limit is reached.

Parameters:
- TICK_DIV, 5000000: clk cycles per game tick (0.1 s at 50 MHz).
- UP_TICKS, 10: ticks a mole stays visible.
- GAP_TICKS, 5: ticks between moles.
- MAX_MISSES, 3: misses that end the game (1..15).
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start/restart pulse (debounced key)
- whack_valid  in  1  one-cycle whack strobe (debounced key)
- whack_idx  in  2  mole hole being whacked, 0..3
- mole_valid  out  1  a mole is currently up
- mole_idx  out  2  index of the current/last mole
- hit_pulse  out  1  one cycle on a scored hit
- miss_pulse  out  1  one cycle on a mole timeout
- score  out  8  hits this game, saturates at 255
- misses  out  4  misses this game
- game_over  out  1  high while in OVER
- seq_state  out  3  current state encoding, for the FSM and LEDs

Behaviour:
- Reset (async, immediate, any state; a reset mid-game abandons it):
  - state=IDLE, LFSR=LFSR_SEED, tick_cnt=0, countdown=0.
  - All outputs 0, including mole_idx=0.
- States: IDLE=0, GAP=1, UP=2, OVER=3.
- Tick generator:
  - tick_cnt counts only in GAP and UP; it is cleared to 0 on every entry to GAP or UP.
  - tick is asserted for one cycle when tick_cnt==TICK_DIV-1; tick_cnt wraps to 0 on that cycle.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle in every state.
- IDLE:
  - On start: go to GAP, set score=0, misses=0, countdown=GAP_TICKS.
- GAP:
  - mole_valid=0. whack_valid and start are ignored.
  - On tick: countdown decrements.
  - On a tick with countdown==1: go to UP, set countdown=UP_TICKS, set mole_valid=1, and latch mole_idx.
  - mole_idx = lfsr[1:0]. If that equals the previous mole_idx, use (lfsr[1:0]+1) mod 4 instead, so the same hole never repeats.
  - Timing: mole_valid rises exactly GAP_TICKS*TICK_DIV clks after the edge that entered GAP.
- UP:
  - Correct whack (whack_valid && whack_idx==mole_idx): hit_pulse=1, score+1 (saturating at 255), mole_valid=0, go to GAP with countdown=GAP_TICKS. All of this takes effect on the next edge.
  - Wrong-index whack: ignored.
  - Timeout (tick with countdown==1): miss_pulse=1, misses+1, mole_valid=0.
    - If the new miss count equals MAX_MISSES, go to OVER; otherwise go to GAP.
  - A correct whack and a timeout in the same cycle count as a hit; no miss is recorded.
  - start is ignored.
- OVER:
  - game_over=1; score, misses and mole_idx hold their values; mole_valid=0.
  - On start: behave exactly as start in IDLE (game_over drops on the next edge).
- hit_pulse and miss_pulse are registered and last exactly one cycle; they are never high together.
- seq_state is the registered state encoding.
- misses never exceeds MAX_MISSES.

Decomposition:
- Shared package whack_pkg contains:
  - state encodings IDLE/GAP/UP/OVER;
  - NUM_MOLES=4 and the mole index width of 2;
  - the LFSR tap constant.
- One sub-module: tick_gen (parameter TICK_DIV; inputs clk, reset, clear, enable; output tick).

Test Plan:
All scenarios use TICK_DIV=4, UP_TICKS=3, GAP_TICKS=2, MAX_MISSES=3.
- Reset, then start pulse: seq_state goes 0→1; mole_valid rises exactly 8 clks later; score=0 and misses=0.
- Correct whack 2 clks after mole_valid rises: hit_pulse for 1 cycle, score=1, mole_valid=0 on the next edge, next mole appears 8 clks later with mole_idx different from the previous mole.
- No whacks for a full game: miss_pulse at 12 clks after each mole_valid rise; after the 3rd miss, misses=3, game_over=1, seq_state=3; score held at 0.
- Wrong-index whack, and a whack during GAP: no pulses, score unchanged, timing unchanged.
- Correct whack in the same cycle as the final tick: hit_pulse=1, miss_pulse=0, misses unchanged.
- Assert reset while mole_valid=1 with score=2: all outputs go to 0 immediately. start in OVER restarts with score=0; 256 forced hits leave score at 255.
